// File: rtl/mb_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mb_scan_ctrl_pkg
// Description : Shared constants and state encoding for the macroblock
//               raster scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package mb_scan_ctrl_pkg;

  localparam int COORD_W_DEF = 10;
  localparam int BND_LAT_DEF = 3;

  // One-hot scheduler states
  typedef enum logic [6:0] {
    ST_IDLE   = 7'b0000001,
    ST_ISSUE  = 7'b0000010,
    ST_WORK   = 7'b0000100,
    ST_SAVE   = 7'b0001000,
    ST_HOLD   = 7'b0010000,
    ST_ADV    = 7'b0100000,
    ST_SETTLE = 7'b1000000
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mb_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mb_scan_ctrl_if
// Description : Scheduler <-> encode core / boundary-save bundle: MB
//               handshake, boundary load strobe and frame geometry.
// Revision    : 1.0 - initial release
// ============================================================================
interface mb_scan_ctrl_if
  import mb_scan_ctrl_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
);

  logic               mb_valid;
  logic               mb_ready;
  logic               mb_done;
  logic               bnd_load;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [COORD_W-1:0] w1;
  logic [COORD_W-1:0] w2;
  logic [COORD_W-1:0] h1;
  logic               last_mb;

  // Scheduler side
  modport master (
    output mb_valid, bnd_load, x, y, w1, w2, h1, last_mb,
    input  mb_ready, mb_done
  );

  // Core / boundary-save side
  modport slave (
    input  mb_valid, bnd_load, x, y, w1, w2, h1, last_mb,
    output mb_ready, mb_done
  );

endinterface
`default_nettype wire

// File: rtl/mb_scan_ctrl_coord_gen.sv
`default_nettype none
// ============================================================================
// Module      : mb_coord_gen
// Description : x/y raster counters with row wrap, last-MB flag and the
//               w1/w2/h1 geometry derived from the latched frame size.
// Revision    : 1.0 - initial release
// ============================================================================
module mb_coord_gen
  import mb_scan_ctrl_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               load,
  input  wire logic               adv,
  input  wire logic [COORD_W-1:0] mb_w,
  input  wire logic [COORD_W-1:0] mb_h,
  output logic      [COORD_W-1:0] x,
  output logic      [COORD_W-1:0] y,
  output logic      [COORD_W-1:0] w1,
  output logic      [COORD_W-1:0] w2,
  output logic      [COORD_W-1:0] h1,
  output logic                    last_mb
);

  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);
  localparam logic [COORD_W-1:0] TWO = COORD_W'(2);

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [COORD_W-1:0] w1_q, w1_d;
  logic [COORD_W-1:0] w2_q, w2_d;
  logic [COORD_W-1:0] h1_q, h1_d;
  // Keeps last_mb low out of reset, when x==w1==0 would otherwise match
  logic               dims_ok_q, dims_ok_d;

  // Coordinate/geometry registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= '0;
      y_q       <= '0;
      w1_q      <= '0;
      w2_q      <= '0;
      h1_q      <= '0;
      dims_ok_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      w1_q      <= w1_d;
      w2_q      <= w2_d;
      h1_q      <= h1_d;
      dims_ok_q <= dims_ok_d;
    end
  end

  // Latch geometry on frame start; raster step with row wrap on adv
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    w1_d      = w1_q;
    w2_d      = w2_q;
    h1_d      = h1_q;
    dims_ok_d = dims_ok_q;
    if (load) begin
      x_d       = '0;
      y_d       = '0;
      w1_d      = mb_w - ONE;
      w2_d      = (mb_w >= TWO) ? (mb_w - TWO) : '0;
      h1_d      = mb_h - ONE;
      dims_ok_d = 1'b1;
    end else if (adv && !last_mb) begin
      // The final MB keeps its coordinates so the frame ends on it
      if (x_q == w1_q) begin
        x_d = '0;
        y_d = y_q + ONE;
      end else begin
        x_d = x_q + ONE;
      end
    end
  end

  assign last_mb = dims_ok_q && (x_q == w1_q) && (y_q == h1_q);
  assign x       = x_q;
  assign y       = y_q;
  assign w1      = w1_q;
  assign w2      = w2_q;
  assign h1      = h1_q;

endmodule
`default_nettype wire

// File: rtl/mb_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mb_scan_ctrl
// Description : Macroblock raster scheduler. Issues each MB to the encode
//               core, strobes the boundary save on completion and waits out
//               the boundary read latency before the next MB.
// Revision    : 1.0 - initial release
// ============================================================================
module mb_scan_ctrl
  import mb_scan_ctrl_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int BND_LAT = BND_LAT_DEF
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               start,
  input  wire logic               abort,
  input  wire logic [COORD_W-1:0] mb_w,
  input  wire logic [COORD_W-1:0] mb_h,
  output logic                    busy,
  output logic                    frame_done,
  mb_scan_ctrl_if.master          core_if
);

  localparam int              CNT_W    = (BND_LAT < 2) ? 1 : $clog2(BND_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BND_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fin_q, fin_d;
  logic               bnd_load_q, bnd_load_d;
  logic               frame_done_q, frame_done_d;
  logic               coord_load;
  logic               coord_adv;
  logic               last_mb;
  logic [COORD_W-1:0] x, y, w1, w2, h1;

  mb_coord_gen #(
    .COORD_W (COORD_W)
  ) u_coord_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (coord_load),
    .adv     (coord_adv),
    .mb_w    (mb_w),
    .mb_h    (mb_h),
    .x       (x),
    .y       (y),
    .w1      (w1),
    .w2      (w2),
    .h1      (h1),
    .last_mb (last_mb)
  );

  // State, settle counter and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      fin_q        <= 1'b0;
      bnd_load_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fin_q        <= fin_d;
      bnd_load_q   <= bnd_load_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state and strobe decode; abort overrides every transition
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fin_d        = fin_q;
    frame_done_d = 1'b0;
    coord_load   = 1'b0;
    coord_adv    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && (mb_w != '0) && (mb_h != '0)) begin
          coord_load = 1'b1;
          fin_d      = 1'b0;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // mb_done is deliberately not looked at until WORK
        if (core_if.mb_ready) state_d = ST_WORK;
      end
      ST_WORK: begin
        if (core_if.mb_done) state_d = ST_SAVE;
      end
      ST_SAVE: state_d = ST_HOLD;
      ST_HOLD: state_d = ST_ADV;
      ST_ADV: begin
        // Remember whether the finished MB closed the frame before x/y move
        coord_adv = 1'b1;
        fin_d     = last_mb;
        cnt_d     = CNT_LOAD;
        state_d   = ST_SETTLE;
      end
      ST_SETTLE: begin
        if ((cnt_q == CNT_ONE) || (cnt_q == '0)) begin
          if (fin_q) begin
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d      = ST_IDLE;
      coord_load   = 1'b0;
      coord_adv    = 1'b0;
      frame_done_d = 1'b0;
    end
    bnd_load_d = (state_d == ST_SAVE);
  end

  assign core_if.mb_valid = (state_q == ST_ISSUE);
  assign core_if.bnd_load = bnd_load_q;
  assign core_if.x        = x;
  assign core_if.y        = y;
  assign core_if.w1       = w1;
  assign core_if.w2       = w2;
  assign core_if.h1       = h1;
  assign core_if.last_mb  = last_mb;
  assign busy             = (state_q != ST_IDLE);
  assign frame_done       = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_mb_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mb_scan_ctrl
// Description : Self-checking bench for mb_scan_ctrl: table of frame shapes
//               driven through a coordinate scoreboard, plus hand-written
//               start/abort/reset corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mb_scan_ctrl;

  localparam int CW = 10;
  localparam int BL = 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] mb_w  = '0;
  logic [CW-1:0] mb_h  = '0;
  logic          busy;
  logic          frame_done;

  mb_scan_ctrl_if #(.COORD_W(CW)) bus ();

  mb_scan_ctrl #(
    .COORD_W (CW),
    .BND_LAT (BL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .mb_w       (mb_w),
    .mb_h       (mb_h),
    .busy       (busy),
    .frame_done (frame_done),
    .core_if    (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w; int h; int rdy_hold; int done_dly;
    int e_w1; int e_w2; int e_h1; int e_bnd;
  } vec_t;

  typedef struct { int x; int y; bit last; } exp_t;

  exp_t sb[$];
  vec_t tbl[5];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   bnd_total = 0;
  int   fd_total  = 0;

  // Independent pulse counters
  always @(negedge clk) begin
    if (bus.bnd_load === 1'b1) bnd_total++;
    if (frame_done === 1'b1) fd_total++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, " ctl"}, 32'({bus.mb_valid, bus.bnd_load, bus.last_mb, busy, frame_done}), 32'd0);
    chk({nm, " x/y/w1"}, 32'({bus.x, bus.y, bus.w1}), 32'd0);
    chk({nm, " w2/h1"}, 32'({bus.w2, bus.h1}), 32'd0);
  endtask

  task automatic serve_mb(input string nm);
    int to = 0;
    while (bus.mb_valid !== 1'b1 && to < 40) begin tick; to++; end
    chk(nm, 32'(bus.mb_valid), 32'd1);
    bus.mb_ready = 1'b1; tick; bus.mb_ready = 1'b0;
    bus.mb_done  = 1'b1; tick; bus.mb_done  = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    int   b0, f0, to, bnd_cyc;
    bit   first;
    exp_t e;
    b0 = bnd_total;
    f0 = fd_total;
    for (int yy = 0; yy < v.h; yy++)
      for (int xx = 0; xx < v.w; xx++) begin
        e.x = xx; e.y = yy; e.last = (xx == v.w - 1) && (yy == v.h - 1);
        sb.push_back(e);
      end
    mb_w = CW'(v.w); mb_h = CW'(v.h); start = 1'b1; tick; start = 1'b0;
    chk("w1", 32'(bus.w1), 32'(v.e_w1));
    chk("w2", 32'(bus.w2), 32'(v.e_w2));
    chk("h1", 32'(bus.h1), 32'(v.e_h1));
    first   = 1'b1;
    bnd_cyc = 0;
    while (sb.size() > 0) begin
      to = 0;
      while (bus.mb_valid !== 1'b1 && to < 40) begin tick; to++; end
      chk("issue valid", 32'(bus.mb_valid), 32'd1);
      if (bus.mb_valid !== 1'b1) begin sb.delete(); return; end
      if (!first) chk("bnd_load to mb_valid gap", 32'(cyc - bnd_cyc), 32'(BL + 3));
      first = 1'b0;
      e = sb.pop_front();
      chk("issue x", 32'(bus.x), 32'(e.x));
      chk("issue y", 32'(bus.y), 32'(e.y));
      chk("issue last_mb", 32'(bus.last_mb), 32'(e.last));
      repeat (v.rdy_hold) begin
        tick;
        chk("bp valid", 32'(bus.mb_valid), 32'd1);
        chk("bp x/y", 32'({bus.x, bus.y}), 32'((e.x << CW) | e.y));
        chk("bp bnd_load", 32'(bus.bnd_load), 32'd0);
      end
      bus.mb_ready = 1'b1; tick; bus.mb_ready = 1'b0;
      chk("work valid", 32'(bus.mb_valid), 32'd0);
      repeat (v.done_dly) begin
        chk("work bnd_load", 32'(bus.bnd_load), 32'd0);
        tick;
      end
      bus.mb_done = 1'b1; tick; bus.mb_done = 1'b0;
      chk("save bnd_load", 32'(bus.bnd_load), 32'd1);
      chk("save x/y", 32'({bus.x, bus.y}), 32'((e.x << CW) | e.y));
      bnd_cyc = cyc;
      tick;
      chk("hold bnd_load", 32'(bus.bnd_load), 32'd0);
      chk("hold x/y", 32'({bus.x, bus.y}), 32'((e.x << CW) | e.y));
    end
    to = 0;
    while (frame_done !== 1'b1 && to < 20) begin tick; to++; end
    chk("frame_done", 32'(frame_done), 32'd1);
    chk("frame_done latency", 32'(cyc - bnd_cyc), 32'(BL + 3));
    tick;
    chk("frame_done pulse width", 32'(frame_done), 32'd0);
    chk("busy after frame", 32'(busy), 32'd0);
    chk("bnd_load count", 32'(bnd_total - b0), 32'(v.e_bnd));
    chk("frame_done count", 32'(fd_total - f0), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int f0;
    vec_t v;
    bus.mb_ready = 1'b0;
    bus.mb_done  = 1'b0;

    //         w  h  hold dly  w1 w2 h1 bnd
    tbl[0] = '{3, 2, 0,   5,   2, 1, 1, 6};
    tbl[1] = '{1, 1, 0,   2,   0, 0, 0, 1};
    tbl[2] = '{2, 1, 10,  3,   1, 0, 0, 2};
    tbl[3] = '{1, 3, 1,   0,   0, 0, 2, 3};
    tbl[4] = '{5, 1, 2,   1,   4, 3, 0, 5};

    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check_zero("reset");

    // Starts with a zero dimension are ignored
    mb_w = 10'd0; mb_h = 10'd3; start = 1'b1; tick; start = 1'b0;
    chk("zero width start busy", 32'(busy), 32'd0);
    mb_w = 10'd3; mb_h = 10'd0; start = 1'b1; tick; start = 1'b0;
    chk("zero height start busy", 32'(busy), 32'd0);
    chk("zero height start w1", 32'(bus.w1), 32'd0);

    for (int i = 0; i < 5; i++) run_frame(tbl[i]);

    // Start while busy, mb_done in ISSUE and together with ready are ignored
    mb_w = 10'd2; mb_h = 10'd2; start = 1'b1; tick; start = 1'b0;
    mb_w = 10'd5; start = 1'b1; tick; start = 1'b0;
    chk("busy start w1", 32'(bus.w1), 32'd1);
    chk("busy start valid", 32'(bus.mb_valid), 32'd1);
    bus.mb_done = 1'b1; tick; bus.mb_done = 1'b0;
    chk("done in issue valid", 32'(bus.mb_valid), 32'd1);
    chk("done in issue bnd_load", 32'(bus.bnd_load), 32'd0);
    bus.mb_ready = 1'b1; bus.mb_done = 1'b1; tick;
    bus.mb_ready = 1'b0; bus.mb_done = 1'b0;
    chk("done with ready valid", 32'(bus.mb_valid), 32'd0);
    tick;
    chk("done with ready bnd_load", 32'(bus.bnd_load), 32'd0);
    tick;
    chk("still working busy", 32'(busy), 32'd1);
    chk("still working bnd_load", 32'(bus.bnd_load), 32'd0);
    abort = 1'b1; tick; abort = 1'b0;
    chk("abort from work busy", 32'(busy), 32'd0);

    // Abort on 4x4 while MB (2,1) is in WORK
    f0 = fd_total;
    mb_w = 10'd4; mb_h = 10'd4; start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < 6; i++) serve_mb("abort walk valid");
    begin
      int to = 0;
      while (bus.mb_valid !== 1'b1 && to < 40) begin tick; to++; end
    end
    chk("abort mb x", 32'(bus.x), 32'd2);
    chk("abort mb y", 32'(bus.y), 32'd1);
    bus.mb_ready = 1'b1; tick; bus.mb_ready = 1'b0;
    tick;
    abort = 1'b1; tick; abort = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort valid", 32'(bus.mb_valid), 32'd0);
    chk("abort x/y kept", 32'({bus.x, bus.y}), 32'((2 << CW) | 1));
    repeat (8) tick;
    chk("abort no frame_done", 32'(fd_total - f0), 32'd0);
    chk("abort no bnd_load", 32'(bus.bnd_load), 32'd0);
    v = '{2, 2, 0, 1, 1, 0, 1, 4};
    run_frame(v);

    // Asynchronous reset while in SETTLE
    mb_w = 10'd2; mb_h = 10'd1; start = 1'b1; tick; start = 1'b0;
    serve_mb("settle test valid");
    tick; tick; tick;
    chk("settle busy", 32'(busy), 32'd1);
    chk("settle x advanced", 32'(bus.x), 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero("async reset");
    @(negedge clk) rst_n = 1'b1;
    tick;
    chk("post reset busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
